// File: rtl/ahb_sd_multisector_reader.sv
// AHB-Lite slave that streams consecutive SD sectors from the SPI sector engine into
// ping-pong sector buffers; the CPU drains each buffer over the bus and hands it back.
module ahb_sd_multisector_reader #(
   parameter logic [31:0] BASE_ADDR    = 32'h4009_0000,
   parameter int          NUM_BUFS     = 2,
   parameter int          SECTOR_BYTES = 512
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   output logic        irq,
   input  logic        sd_init_done,
   output logic        sd_sec_read,
   output logic [31:0] sd_sec_read_addr,
   input  logic [7:0]  sd_sec_read_data,
   input  logic        sd_sec_read_data_valid,
   input  logic        sd_sec_read_end
);
   localparam int WORDS = SECTOR_BYTES / 4;
   localparam int DEPTH = NUM_BUFS * WORDS;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = $clog2(NUM_BUFS);
   localparam int WW    = $clog2(WORDS);
   localparam logic [BW-1:0] BUF_ONE  = 1;
   localparam logic [31:0]   BUF_SPAN = 32'(NUM_BUFS * SECTOR_BYTES);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_READ, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [31:0]         start_lba_q, start_lba_d;
   logic [31:0]         cur_lba_q, cur_lba_d;
   logic [15:0]         count_q, count_d;
   logic [15:0]         remain_q, remain_d;
   logic                irq_en_q, irq_en_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                irq_q, irq_d;
   logic                sd_rd_q, sd_rd_d;
   logic                abort_pend_q, abort_pend_d;
   logic [NUM_BUFS-1:0] full_q, full_d;
   logic [BW-1:0]       wbuf_q, wbuf_d;
   logic [BW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [9:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [11:0]         waddr_q, waddr_d;
   logic                sel_buf_q, sel_buf_d;
   logic [31:0]         reg_rd_q, reg_rd_d;

   logic [3:0][7:0]     ram [DEPTH];
   logic [31:0]         ram_rdata;
   logic                ram_we;
   logic [AW-1:0]       ram_waddr;

   logic                hit, is_buf, acc, start_p, abort_p;
   logic [3:0]          full4;
   logic [7:0]          rptr8;
   logic [31:0]         status;
   logic                unused_ok;

   assign hit       = HADDR[31:12] == BASE_ADDR[31:12];
   assign is_buf    = {20'd0, HADDR[11:0]} < BUF_SPAN;
   assign acc       = HSEL & HREADY & HTRANS[1] & hit;
   assign unused_ok = &{1'b0, HSIZE, HTRANS[0]};

   assign HREADYOUT        = 1'b1;
   assign HRESP            = 1'b0;
   assign HRDATA           = sel_buf_q ? ram_rdata : reg_rd_q;
   assign irq              = irq_q;
   assign sd_sec_read      = sd_rd_q;
   assign sd_sec_read_addr = cur_lba_q;

   always_comb begin
      full4              = '0;
      full4[NUM_BUFS-1:0] = full_q;
      rptr8              = '0;
      rptr8[BW-1:0]      = rd_ptr_q;
      status = {16'd0, rptr8, full4, err_q, done_q, (state_q != S_IDLE), sd_init_done};
   end

   always_comb begin
      state_d      = state_q;
      start_lba_d  = start_lba_q;
      cur_lba_d    = cur_lba_q;
      count_d      = count_q;
      remain_d     = remain_q;
      irq_en_d     = irq_en_q;
      done_d       = done_q;
      err_d        = err_q;
      sd_rd_d      = sd_rd_q;
      abort_pend_d = abort_pend_q;
      full_d       = full_q;
      wbuf_d       = wbuf_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      start_p      = 1'b0;
      abort_p      = 1'b0;
      ram_we       = 1'b0;
      ram_waddr    = {wbuf_q, cnt_q[WW+1:2]};

      // Address phase: latch writes for the data phase, select read source now
      wr_d      = acc & HWRITE & ~is_buf;
      waddr_d   = HADDR[11:0];
      sel_buf_d = acc & ~HWRITE & is_buf;
      reg_rd_d  = '0;
      if (acc && !HWRITE && !is_buf) begin
         case (HADDR[11:0])
            12'h800: reg_rd_d = start_lba_q;
            12'h804: reg_rd_d = {16'd0, count_q};
            12'h808: reg_rd_d = {29'd0, irq_en_q, 2'b00};
            12'h80C: reg_rd_d = status;
            12'h810: reg_rd_d = cur_lba_q;
            12'h814: reg_rd_d = {16'd0, remain_q};
            default: reg_rd_d = '0;
         endcase
      end

      if (wr_q) begin
         case (waddr_q)
            12'h800: start_lba_d = HWDATA;
            12'h804: count_d     = HWDATA[15:0];
            12'h808: begin
               start_p  = HWDATA[0];
               abort_p  = HWDATA[1];
               irq_en_d = HWDATA[2];
            end
            12'h80C: begin
               done_d = done_q & ~HWDATA[2];
               err_d  = err_q & ~HWDATA[3];
            end
            12'h818: begin
               full_d[HWDATA[BW-1:0]] = 1'b0;
               rd_ptr_d               = HWDATA[BW-1:0] + BUF_ONE;
            end
            default: ;
         endcase
      end

      // Sector FSM; a completing sector's FULL set overrides a same-cycle RELEASE
      case (state_q)
         S_IDLE: begin
            if (start_p && sd_init_done && count_q != 16'd0) state_d = S_LOAD;
         end
         S_LOAD: begin
            cur_lba_d = start_lba_q;
            remain_d  = count_q;
            wbuf_d    = '0;
            rd_ptr_d  = '0;
            full_d    = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            state_d   = abort_p ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (abort_p) begin
               state_d = S_IDLE;
            end else if (!full_q[wbuf_q]) begin
               state_d = S_READ;
               sd_rd_d = 1'b1;
               cnt_d   = '0;
            end
         end
         S_READ: begin
            if (abort_p) abort_pend_d = 1'b1;
            if (sd_sec_read_data_valid) begin
               if (cnt_q < 10'd512) begin
                  ram_we = 1'b1;
                  cnt_d  = cnt_q + 10'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (sd_sec_read_end) begin
               sd_rd_d      = 1'b0;
               abort_pend_d = 1'b0;
               if (abort_pend_q || abort_p) begin
                  state_d = S_IDLE;
               end else begin
                  if (cnt_d != 10'd512) err_d = 1'b1;
                  full_d[wbuf_q] = 1'b1;
                  wbuf_d         = wbuf_q + BUF_ONE;
                  cur_lba_d      = cur_lba_q + 32'd1;
                  remain_d       = remain_q - 16'd1;
                  state_d        = (remain_q == 16'd1) ? S_DONE : S_WAIT;
               end
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE && !sd_init_done) begin
         err_d        = 1'b1;
         sd_rd_d      = 1'b0;
         abort_pend_d = 1'b0;
         state_d      = S_IDLE;
      end

      irq_d = irq_en_d & (done_d | err_d);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= S_IDLE;
         start_lba_q  <= '0;
         cur_lba_q    <= '0;
         count_q      <= '0;
         remain_q     <= '0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         irq_q        <= 1'b0;
         sd_rd_q      <= 1'b0;
         abort_pend_q <= 1'b0;
         full_q       <= '0;
         wbuf_q       <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         waddr_q      <= '0;
         sel_buf_q    <= 1'b0;
         reg_rd_q     <= '0;
      end else begin
         state_q      <= state_d;
         start_lba_q  <= start_lba_d;
         cur_lba_q    <= cur_lba_d;
         count_q      <= count_d;
         remain_q     <= remain_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         err_q        <= err_d;
         irq_q        <= irq_d;
         sd_rd_q      <= sd_rd_d;
         abort_pend_q <= abort_pend_d;
         full_q       <= full_d;
         wbuf_q       <= wbuf_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         waddr_q      <= waddr_d;
         sel_buf_q    <= sel_buf_d;
         reg_rd_q     <= reg_rd_d;
      end
   end

   // Buffer RAM: byte-lane writes from the engine, synchronous word reads for the bus
   always_ff @(posedge HCLK) begin
      if (ram_we) ram[ram_waddr][cnt_q[1:0]] <= sd_sec_read_data;
      ram_rdata <= ram[HADDR[AW+1:2]];
   end

endmodule

// File: tb/tb_ahb_sd_multisector_reader.sv
// Directed-random bench for ahb_sd_multisector_reader: an SD engine model feeds sectors
// while the main sequence drives AHB and compares against a sector-level reference model.
module tb_ahb_sd_multisector_reader;
   localparam logic [31:0] BASE = 32'h4009_0000;
   localparam int          NB   = 2;
   localparam logic [31:0] A_LBA = BASE + 32'h800, A_CNT = BASE + 32'h804, A_CTRL = BASE + 32'h808;
   localparam logic [31:0] A_ST  = BASE + 32'h80C, A_CUR = BASE + 32'h810, A_REM  = BASE + 32'h814;
   localparam logic [31:0] A_REL = BASE + 32'h818;

   logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [2:0]  HSIZE = 3'b010;
   logic [31:0] HADDR = '0, HWDATA = '0;
   logic        HREADYOUT, HRESP, irq, sd_sec_read;
   logic [31:0] HRDATA, sd_sec_read_addr;
   logic        sd_init_done = 1'b0;
   logic [7:0]  sd_sec_read_data = '0;
   logic        sd_sec_read_data_valid = 1'b0, sd_sec_read_end = 1'b0;

   int          n_assert = 0, n_fail = 0;
   logic [31:0] req_q[$];
   int          len_q[$];
   int          eng_bytes = 0;

   ahb_sd_multisector_reader #(.BASE_ADDR(BASE), .NUM_BUFS(NB), .SECTOR_BYTES(512)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .irq(irq),
      .sd_init_done(sd_init_done), .sd_sec_read(sd_sec_read),
      .sd_sec_read_addr(sd_sec_read_addr), .sd_sec_read_data(sd_sec_read_data),
      .sd_sec_read_data_valid(sd_sec_read_data_valid), .sd_sec_read_end(sd_sec_read_end)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [7:0] pat(input logic [31:0] lba, input int k);
      logic [31:0] m;
      m = lba * 32'd37;
      return 8'(k) ^ m[7:0];
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] lba, input int w);
      return {pat(lba, 4*w+3), pat(lba, 4*w+2), pat(lba, 4*w+1), pat(lba, 4*w)};
   endfunction

   function automatic logic [31:0] exp_st(input bit init, input bit busy, input bit done,
                                          input bit err, input logic [3:0] full,
                                          input logic [7:0] rptr);
      return {16'd0, rptr, full, err, done, busy, init};
   endfunction

   // Buffers filled by n consecutive sectors starting at buffer 0
   function automatic logic [3:0] land_mask(input int n);
      logic [3:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i % NB] = 1'b1;
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      @(posedge HCLK); #1;
   endtask

   task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      ahb_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic chk_word(input string tag, input int b, input int w, input logic [31:0] lba);
      logic [31:0] d;
      ahb_read(BASE + 32'(b*512 + w*4), d);
      check(tag, d, exp_word(lba, w));
   endtask

   task automatic wait_status(input string tag, input logic [31:0] mask, input logic [31:0] val);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 2000; i++) begin
         ahb_read(A_ST, s);
         if ((s & mask) == val) break;
      end
      check(tag, s & mask, val);
   endtask

   task automatic check_reqs(input string tag, input logic [31:0] lba0, input int n);
      check({tag, "_nreq"}, req_q.size(), n);
      for (int i = 0; i < n && req_q.size() > 0; i++) check({tag, "_lba"}, req_q.pop_front(), lba0 + i);
      req_q.delete();
   endtask

   task automatic start_xfer(input logic [31:0] lba, input logic [15:0] cnt);
      eng_bytes = 0;
      ahb_write(A_LBA, lba);
      ahb_write(A_CNT, {16'd0, cnt});
      ahb_write(A_ST, 32'hC);
      ahb_write(A_CTRL, 32'h5);
      repeat (3) @(posedge HCLK);
      #1;
   endtask

   // SD sector engine model: answers each request with len bytes then an end pulse
   initial begin
      int len;
      logic [31:0] lba;
      forever begin
         @(posedge HCLK); #1;
         if (sd_sec_read === 1'b1) begin
            lba = sd_sec_read_addr;
            req_q.push_back(lba);
            len = (len_q.size() > 0) ? len_q.pop_front() : 512;
            eng_bytes = 0;
            repeat ($urandom_range(0, 3)) begin @(posedge HCLK); #1; end
            for (int k = 0; k < len; k++) begin
               sd_sec_read_data       = pat(lba, k);
               sd_sec_read_data_valid = 1'b1;
               eng_bytes              = k + 1;
               @(posedge HCLK); #1;
               sd_sec_read_data_valid = 1'b0;
               if ($urandom_range(0, 3) == 0) begin @(posedge HCLK); #1; end
            end
            sd_sec_read_end = 1'b1;
            @(posedge HCLK); #1;
            sd_sec_read_end = 1'b0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d1, d2, lba;
      logic [3:0]  fm;

      // Reset state
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_irq", irq, 1'b0);
      check("rst_sdrd", sd_sec_read, 1'b0);
      check("rst_hreadyout", HREADYOUT, 1'b1);
      check("rst_hresp", HRESP, 1'b0);
      HRESETn = 1'b1;
      chk_reg("rst_status", A_ST, 32'h0);
      chk_reg("rst_lba", A_LBA, 32'h0);

      // START ignored without a card, and with COUNT=0
      ahb_write(A_LBA, 32'h55);
      ahb_write(A_CNT, 32'h1);
      ahb_write(A_CTRL, 32'h1);
      repeat (20) @(posedge HCLK);
      #1;
      chk_reg("noinit_status", A_ST, 32'h0);
      check("noinit_req", req_q.size(), 0);
      sd_init_done = 1'b1;
      ahb_write(A_CNT, 32'h0);
      ahb_write(A_CTRL, 32'h1);
      repeat (20) @(posedge HCLK);
      #1;
      chk_reg("cnt0_status", A_ST, exp_st(1, 0, 0, 0, 4'h0, 8'h0));
      check("cnt0_req", req_q.size(), 0);
      chk_reg("ctrl_selfclr", A_CTRL, 32'h0);
      chk_reg("unmapped", BASE + 32'h81C, 32'h0);
      chk_reg("offbase", 32'h4008_0800, 32'h0);

      // Single sector at LBA 0x100
      start_xfer(32'h100, 16'd1);
      wait_status("t1_done", 32'h6, 32'h4);
      check_reqs("t1", 32'h100, 1);
      chk_reg("t1_status", A_ST, exp_st(1, 0, 1, 0, land_mask(1), 8'h0));
      check("t1_irq", irq, 1'b1);
      chk_reg("t1_remain", A_REM, 32'h0);
      chk_reg("t1_cur", A_CUR, 32'h101);
      chk_reg("t1_ctrl", A_CTRL, 32'h4);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = BASE;
      @(posedge HCLK); #1;
      HADDR = A_ST;
      d1 = HRDATA;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d2 = HRDATA;
      check("b2b_word0", d1, 32'h0302_0100);
      check("b2b_status", d2, exp_st(1, 0, 1, 0, land_mask(1), 8'h0));
      chk_word("t1_w127", 0, 127, 32'h100);
      ahb_write(A_ST, 32'h4);
      check("t1_irq_clr", irq, 1'b0);

      // Three sectors, no release: stall with two full buffers
      lba = $urandom;
      start_xfer(lba, 16'd3);
      wait_status("t3_full", 32'hF0, {24'd0, land_mask(2), 4'h0});
      repeat (20) @(posedge HCLK);
      #1;
      check("t3_stall_sdrd", sd_sec_read, 1'b0);
      chk_reg("t3_stall_status", A_ST, exp_st(1, 1, 0, 0, land_mask(2), 8'h0));
      chk_reg("t3_stall_remain", A_REM, 32'h1);
      ahb_write(A_CTRL, 32'h5);
      chk_reg("t3_busy_start_cur", A_CUR, lba + 2);
      chk_word("t3_buf0", 0, $urandom_range(0, 127), lba);
      chk_word("t3_buf1", 1, $urandom_range(0, 127), lba + 1);
      ahb_write(A_REL, 32'h0);
      wait_status("t3_done", 32'h6, 32'h4);
      chk_reg("t3_status", A_ST, exp_st(1, 0, 1, 0, land_mask(2), 8'h1));
      chk_reg("t3_remain", A_REM, 32'h0);
      chk_reg("t3_cur", A_CUR, lba + 3);
      chk_word("t3_buf0_third", 0, $urandom_range(0, 127), lba + 2);
      check_reqs("t3", lba, 3);
      check("t3_irq", irq, 1'b1);

      // Short first sector (500 bytes) flags ERR but the transfer continues
      lba = $urandom;
      len_q.push_back(500);
      start_xfer(lba, 16'd2);
      wait_status("t4_done", 32'h6, 32'h4);
      chk_reg("t4_status", A_ST, exp_st(1, 0, 1, 1, land_mask(2), 8'h0));
      check_reqs("t4", lba, 2);
      chk_word("t4_buf0", 0, $urandom_range(0, 124), lba);
      chk_word("t4_buf1", 1, 127, lba + 1);
      ahb_write(A_ST, 32'hC);
      chk_reg("t4_w1c", A_ST, exp_st(1, 0, 0, 0, land_mask(2), 8'h0));
      check("t4_irq_clr", irq, 1'b0);

      // Over-long sector: extra bytes dropped and flagged
      lba = $urandom;
      len_q.push_back(514);
      start_xfer(lba, 16'd1);
      wait_status("t5_done", 32'h6, 32'h4);
      chk_reg("t5_status", A_ST, exp_st(1, 0, 1, 1, land_mask(1), 8'h0));
      chk_word("t5_w127", 0, 127, lba);
      check_reqs("t5", lba, 1);

      // ABORT in the middle of a sector
      lba = $urandom;
      start_xfer(lba, 16'd2);
      for (int i = 0; i < 3000 && eng_bytes < 200; i++) @(posedge HCLK);
      #1;
      check("t6_reach200", (eng_bytes >= 200), 1'b1);
      ahb_write(A_CTRL, 32'h6);
      check("t6_sdrd_held", sd_sec_read, 1'b1);
      wait_status("t6_idle", 32'h2, 32'h0);
      chk_reg("t6_status", A_ST, exp_st(1, 0, 0, 0, 4'h0, 8'h0));
      check("t6_sdrd", sd_sec_read, 1'b0);
      repeat (30) @(posedge HCLK);
      #1;
      check_reqs("t6", lba, 1);

      // ABORT while stalled for a free buffer
      lba = $urandom;
      start_xfer(lba, 16'd3);
      wait_status("t7_full", 32'hF0, {24'd0, land_mask(2), 4'h0});
      ahb_write(A_CTRL, 32'h6);
      chk_reg("t7_status", A_ST, exp_st(1, 0, 0, 0, land_mask(2), 8'h0));
      check("t7_irq", irq, 1'b0);
      check_reqs("t7", lba, 2);

      // Card loss while busy
      lba = $urandom;
      start_xfer(lba, 16'd3);
      wait_status("t8_full", 32'hF0, {24'd0, land_mask(2), 4'h0});
      sd_init_done = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      fm = land_mask(2);
      chk_reg("t8_status", A_ST, exp_st(0, 0, 0, 1, fm, 8'h0));
      check("t8_irq", irq, 1'b1);
      check("t8_sdrd", sd_sec_read, 1'b0);
      check_reqs("t8", lba, 2);
      sd_init_done = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
